// File: rtl/event_sram_model_if.sv
// ---------------------------------------------------------------------------
// event_sram_model_if
// Request/response bundle between the event queue controller (master) and
// the event SRAM model (slave).
//   addr       word address for a read or write
//   din        write data
//   wmask      per-lane write enable, bit i covers din[i*LANE_BITS +: LANE_BITS]
//   wr_en      write request
//   sense_en   read request
//   dout       read data, holds the last read value between reads
//   dout_valid one-cycle strobe when dout carries new read data
//   ready      high once the post-reset zero-fill has finished
// With EVENT_SRAM_PARITY_EN defined the bundle also carries:
//   inj_par_err  inverts stored parity of the lanes being written
//   parity_err   flags a parity failure in the word returned with dout_valid
// ---------------------------------------------------------------------------
interface event_sram_model_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int LANES  = 4
);
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  din;
    logic [LANES-1:0]  wmask;
    logic              wr_en;
    logic              sense_en;
    logic [WIDTH-1:0]  dout;
    logic              dout_valid;
    logic              ready;
`ifdef EVENT_SRAM_PARITY_EN
    logic              inj_par_err;
    logic              parity_err;

    modport master (
        output addr, din, wmask, wr_en, sense_en, inj_par_err,
        input  dout, dout_valid, ready, parity_err
    );
    modport slave (
        input  addr, din, wmask, wr_en, sense_en, inj_par_err,
        output dout, dout_valid, ready, parity_err
    );
`else
    modport master (
        output addr, din, wmask, wr_en, sense_en,
        input  dout, dout_valid, ready
    );
    modport slave (
        input  addr, din, wmask, wr_en, sense_en,
        output dout, dout_valid, ready
    );
`endif
endinterface

// File: rtl/event_sram_model.sv
// ---------------------------------------------------------------------------
// event_sram_model
// Behavioural single-port SRAM standing in for the hard event-queue macro.
// Lane-masked writes, READ_LATENCY-cycle reads with a valid strobe, and a
// zero-fill of every word after reset (ready stays low for DEPTH cycles).
//
// Ports:
//   clk  sole clock, all logic on posedge
//   rst  synchronous reset, active-high
//   bus  event_sram_model_if.slave (addr/din/wmask/wr_en/sense_en in,
//        dout/dout_valid/ready out)
//
// Optional feature macro: EVENT_SRAM_PARITY_EN
//   Stores one even-parity bit per lane, adds inj_par_err / parity_err on
//   the interface. Undefined: no parity storage, no extra signals.
// ---------------------------------------------------------------------------
module event_sram_model #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int LANE_BITS    = WIDTH,
    parameter int READ_LATENCY = 1,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int LANES       = WIDTH / LANE_BITS
) (
    input  logic              clk,
    input  logic              rst,
    event_sram_model_if.slave bus
);

    if (WIDTH % LANE_BITS != 0) begin : g_bad_lane_bits
        $error("event_sram_model: WIDTH must be a multiple of LANE_BITS");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("event_sram_model: READ_LATENCY must be 1..4");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("event_sram_model: DEPTH must be at least 2");
    end

`ifdef EVENT_SRAM_PARITY_EN
    localparam int PAY_W = WIDTH + 1;   // read payload carries the parity flag on top
`else
    localparam int PAY_W = WIDTH;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fill_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              addr_ok;
    logic              wr_fire;
    logic              rd_fire;
    logic [WIDTH-1:0]  rd_word;
    logic [PAY_W-1:0]  rd_pay;
    logic              tap_vld;
    logic [PAY_W-1:0]  tap_pay;

    function automatic logic [LANES-1:0] lane_parity(input logic [WIDTH-1:0] w);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^w[i*LANE_BITS +: LANE_BITS];
        end
        return p;
    endfunction

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign addr_ok = int'(bus.addr) < DEPTH;
    assign wr_fire = bus.ready && !rst && bus.wr_en && addr_ok;
    // A colliding write wins, so a read only fires with wr_en low.
    assign rd_fire = bus.ready && !rst && bus.sense_en && !bus.wr_en;
    assign rd_word = addr_ok ? mem[bus.addr] : '0;

    always_ff @(posedge clk) begin
        if (state == INIT && !rst) begin
            mem[fill_ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wmask[i]) begin
                    mem[bus.addr][i*LANE_BITS +: LANE_BITS] <= bus.din[i*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end

`ifdef EVENT_SRAM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] din_par;
    logic             rd_perr;

    assign din_par = lane_parity(bus.din);
    assign rd_perr = addr_ok && (|(lane_parity(rd_word) ^ par_mem[bus.addr]));
    assign rd_pay  = {rd_perr, rd_word};

    always_ff @(posedge clk) begin
        if (state == INIT && !rst) begin
            par_mem[fill_ptr] <= '0;   // parity of an all-zero lane is 0
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wmask[i]) begin
                    par_mem[bus.addr][i] <= din_par[i] ^ bus.inj_par_err;
                end
            end
        end
    end
`else
    assign rd_pay = rd_word;
`endif

    // Read pipeline: stage k holds a read captured k edges ago; the last
    // stage feeds dout on edge capture+READ_LATENCY-1.
    if (READ_LATENCY == 1) begin : g_lat1
        assign tap_vld = rd_fire;
        assign tap_pay = rd_pay;
    end else begin : g_pipe
        logic             vld_p [READ_LATENCY-1];
        logic [PAY_W-1:0] pay_p [READ_LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < READ_LATENCY - 1; k++) begin
                    vld_p[k] <= 1'b0;
                end
            end else begin
                vld_p[0] <= rd_fire;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    vld_p[k] <= vld_p[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pay_p[0] <= rd_pay;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
                pay_p[k] <= pay_p[k-1];
            end
        end

        assign tap_vld = vld_p[READ_LATENCY-2];
        assign tap_pay = pay_p[READ_LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= INIT;
            fill_ptr       <= '0;
            bus.ready      <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
`ifdef EVENT_SRAM_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                INIT: begin
                    fill_ptr <= fill_ptr + 1'b1;
                    if (fill_ptr == ADDR_W'(DEPTH - 1)) begin
                        state     <= RUN;
                        bus.ready <= 1'b1;
                    end
                end
                default: ;
            endcase
            bus.dout_valid <= tap_vld;
            if (tap_vld) begin
                bus.dout <= tap_pay[WIDTH-1:0];
            end
`ifdef EVENT_SRAM_PARITY_EN
            bus.parity_err <= tap_vld && tap_pay[WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_event_sram_model.sv
// ---------------------------------------------------------------------------
// tb_event_sram_model
// Directed + random bench for event_sram_model (WIDTH=32, DEPTH=12,
// LANE_BITS=8, READ_LATENCY=3). A reference model keeps the memory as a
// plain array and the outstanding reads as a queue of (due cycle, data).
// ---------------------------------------------------------------------------
module tb_event_sram_model;
    localparam int W     = 32;
    localparam int DEPTH = 12;
    localparam int LB    = 8;
    localparam int RL    = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int LN    = W / LB;

    typedef struct {
        int          due;
        logic [W-1:0] data;
        logic        perr;
    } rd_t;

    logic clk;
    logic rst;

    event_sram_model_if #(.WIDTH(W), .ADDR_W(AW), .LANES(LN)) bus ();

    event_sram_model #(
        .WIDTH(W), .DEPTH(DEPTH), .LANE_BITS(LB), .READ_LATENCY(RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [W-1:0]  m_mem [DEPTH];
    logic [LN-1:0] m_bad [DEPTH];
    rd_t           q [$];
    logic          m_ready;
    int            fill_cnt;
    int            cyc;
    logic [W-1:0]  exp_dout;
    logic          exp_vld;
    logic          exp_perr;

    int errors = 0;
    int checks = 0;

    task automatic step(input logic r, input logic w, input logic s,
                        input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [LN-1:0] m, input logic inj);
        rd_t e;
        rst          = r;
        bus.wr_en    = w;
        bus.sense_en = s;
        bus.addr     = a;
        bus.din      = d;
        bus.wmask    = m;
`ifdef EVENT_SRAM_PARITY_EN
        bus.inj_par_err = inj;
`endif
        @(posedge clk);
        exp_vld  = 1'b0;
        exp_perr = 1'b0;
        if (r) begin
            m_ready  = 1'b0;
            fill_cnt = 0;
            q.delete();
            exp_dout = '0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_bad[i] = '0;
            end
        end else if (!m_ready) begin
            fill_cnt++;
            if (fill_cnt == DEPTH) m_ready = 1'b1;
        end else if (w) begin
            if (int'(a) < DEPTH) begin
                for (int i = 0; i < LN; i++) begin
                    if (m[i]) begin
                        m_mem[a][i*LB +: LB] = d[i*LB +: LB];
`ifdef EVENT_SRAM_PARITY_EN
                        m_bad[a][i] = inj;
`endif
                    end
                end
            end
        end else if (s) begin
            e.due  = cyc + RL - 1;
            e.data = (int'(a) < DEPTH) ? m_mem[a] : '0;
            e.perr = (int'(a) < DEPTH) ? (|m_bad[a]) : 1'b0;
            q.push_back(e);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_vld  = 1'b1;
            exp_dout = q[0].data;
            exp_perr = q[0].perr;
            void'(q.pop_front());
        end
        cyc++;
        #1;
        checks++;
        assert (bus.ready === m_ready) else begin
            errors++;
            $error("FAIL ready cyc=%0d observed=%0b expected=%0b", cyc, bus.ready, m_ready);
        end
        checks++;
        assert (bus.dout_valid === exp_vld) else begin
            errors++;
            $error("FAIL dout_valid cyc=%0d observed=%0b expected=%0b", cyc, bus.dout_valid, exp_vld);
        end
        checks++;
        assert (bus.dout === exp_dout) else begin
            errors++;
            $error("FAIL dout cyc=%0d observed=%h expected=%h", cyc, bus.dout, exp_dout);
        end
`ifdef EVENT_SRAM_PARITY_EN
        checks++;
        assert (bus.parity_err === exp_perr) else begin
            errors++;
            $error("FAIL parity_err cyc=%0d observed=%0b expected=%0b", cyc, bus.parity_err, exp_perr);
        end
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic [LN-1:0] m, input logic inj);
        step(1'b0, 1'b1, 1'b0, a, d, m, inj);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 1'b1, a, $urandom, LN'($urandom), 1'b0);
    endtask

    task automatic noisy_fill();
        // requests while ready is low must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), $urandom, LN'($urandom), 1'b0);
        end
    endtask

    initial begin
        cyc      = 0;
        m_ready  = 1'b0;
        fill_cnt = 0;
        exp_dout = '0;

        // reset state
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b1, '0, '1, '1, 1'b0);
        noisy_fill();
        idle();

        // load every word
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), $urandom, '1, 1'b0);

        // masked write
        wr(4'd3, 32'hAABBCCDD, 4'b1111, 1'b0);
        wr(4'd3, 32'h11223344, 4'b0101, 1'b0);
        rd(4'd3);
        idle();
        idle();
        checks++;
        assert (bus.dout_valid === 1'b1 && bus.dout === 32'hAA22CC44) else begin
            errors++;
            $error("FAIL masked_write observed=%h/%0b expected=aa22cc44/1", bus.dout, bus.dout_valid);
        end

        // back-to-back reads with latency 3
        for (int a = 0; a < 4; a++) rd(AW'(a));
        repeat (3) idle();

        // collision: write wins, no read strobe
        step(1'b0, 1'b1, 1'b1, 4'd7, 32'hCAFE0007, '1, 1'b0);
        rd(4'd7);
        repeat (2) idle();

        // read right after write, and wmask=0 no-op
        wr(4'd9, 32'h0BADF00D, '1, 1'b0);
        wr(4'd9, 32'hFFFFFFFF, '0, 1'b0);
        rd(4'd9);
        repeat (2) idle();

        // out of range: write dropped, read returns zero with normal timing
        wr(4'd13, 32'h12345678, '1, 1'b0);
        rd(4'd13);
        rd(4'd15);
        repeat (2) idle();

        // random traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
                 AW'($urandom), $urandom, LN'($urandom), ($urandom_range(0, 9) == 0));
        end
        repeat (DEPTH + 3) idle();

        // reset fill clears all words
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'hFFFFFFFF, '1, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        noisy_fill();
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        repeat (3) idle();

        // reset while a read is in flight
        wr(4'd2, 32'h5A5A5A5A, '1, 1'b0);
        rd(4'd2);
        rd(4'd2);
        rd(4'd2);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        noisy_fill();
        repeat (3) idle();

`ifdef EVENT_SRAM_PARITY_EN
        wr(4'd5, 32'h01020304, '1, 1'b1);
        rd(4'd5);
        repeat (2) idle();
        checks++;
        assert (bus.parity_err === 1'b1 && bus.dout_valid === 1'b1) else begin
            errors++;
            $error("FAIL parity_inject observed=%0b expected=1", bus.parity_err);
        end
        wr(4'd5, 32'h01020304, '1, 1'b0);
        rd(4'd5);
        repeat (2) idle();
        checks++;
        assert (bus.parity_err === 1'b0 && bus.dout_valid === 1'b1) else begin
            errors++;
            $error("FAIL parity_clear observed=%0b expected=0", bus.parity_err);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
